neuron_weight_sequencer: RTL and testbench
==========================================

NEURON_WEIGHT_SEQUENCER -- requirements
Module: neuron_weight_sequencer

Interface
REQ-001 Parameter DEPTH, default 28: number of weight words per neuron; valid addresses are 0..DEPTH-1.
REQ-002 Parameter AW, default 5: BRAM address width.
REQ-003 Parameter DW, default 16: weight word width.
REQ-004 CLK  in  1: single clock; all state updates on the rising edge.
REQ-005 RST  in  1: synchronous, active-high reset.
REQ-006 LD_REQ  in  1: host requests to write one weight word.
REQ-007 LD_ADDR  in  AW: target address of the write.
REQ-008 LD_DATA  in  DW: weight value to write.
REQ-009 LD_GNT  out  1: combinational; write accepted this cycle.
REQ-010 LD_ERR  out  1: registered one-cycle pulse; a granted write had LD_ADDR >= DEPTH.
REQ-011 START  in  1: request to stream all DEPTH weights.
REQ-012 STALL  in  1: consumer backpressure; suppresses new read issue.
REQ-013 BUSY  out  1: registered; stream in progress.
REQ-014 W_VALID  out  1: registered; W_DATA and W_IDX are valid.
REQ-015 W_IDX  out  AW: registered; address of the word on W_DATA.
REQ-016 W_DATA  out  DW: combinational pass-through of BRAM_DO.
REQ-017 DONE  out  1: registered one-cycle pulse marking the last streamed word.
REQ-018 BRAM_ADDR  out  AW, BRAM_DI  out  DW, BRAM_EN  out  1, BRAM_WE  out  1: combinational drive to the weight BRAM.
REQ-019 BRAM_DO  in  DW: BRAM read data, updated on the falling CLK edge after an enabled read; holds when BRAM_EN=0.

Function
REQ-020 FSM states SHALL be IDLE, STREAM, DRAIN.
REQ-021 In IDLE with LD_REQ=1 and RST=0: LD_GNT=1, BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=LD_ADDR, BRAM_DI=LD_DATA, all in the same cycle.
REQ-022 Granted write with LD_ADDR >= DEPTH: BRAM_EN=0; LD_ERR=1 on the next cycle; no BRAM write.
REQ-023 LD_GNT SHALL be 0 in STREAM and DRAIN; the host holds LD_REQ until granted.
REQ-024 Load has priority in IDLE. START together with LD_REQ sets a pending-start flag. The stream begins in the first IDLE cycle with LD_REQ=0.
REQ-025 IDLE, LD_REQ=0, and (START=1 or pending set): go to STREAM; clear pending; read counter=0; BUSY=1 from the next cycle.
REQ-026 In STREAM with STALL=0: BRAM_EN=1, BRAM_WE=0, BRAM_ADDR=counter; counter increments.
REQ-027 In STREAM with STALL=1: BRAM_EN=0; counter holds; no read is issued.
REQ-028 Issuing address DEPTH-1 SHALL move the FSM to DRAIN. In DRAIN, BRAM_EN=0 for one cycle, then the FSM returns to IDLE.
REQ-029 Latency: read issued at rising edge t -> W_VALID=1, W_IDX=issued address at edge t+1. W_VALID=0 in cycles following no issue.
REQ-030 DONE=1 exactly in the cycle W_VALID=1 with W_IDX=DEPTH-1. BUSY falls in the cycle after DONE.
REQ-031 START in STREAM or DRAIN SHALL be ignored and SHALL NOT set pending.
REQ-032 STALL in IDLE or DRAIN SHALL have no effect.
REQ-033 The counter width is AW and never exceeds DEPTH-1; there is no wrap-around.

Reset
REQ-034 While RST=1 (combinational override): LD_GNT=0, BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_DI=0.
REQ-035 On the reset edge: state=IDLE; counter=0; pending=0; BUSY=0; W_VALID=0; W_IDX=0; DONE=0; LD_ERR=0.
REQ-036 RST during STREAM aborts the stream with no DONE. START is accepted on the first cycle after RST falls.

Verification
REQ-037 Load: write 0x0001..0x001C to addresses 0..27, then START -> exactly 28 W_VALID cycles; W_IDX 0..27; W_DATA=W_IDX+1; DONE only with W_IDX=27.
REQ-038 Latency: START at cycle 0 -> BRAM_ADDR=0 at cycle 1; W_VALID, W_IDX=0 at cycle 2; DONE at cycle 29; BUSY=0 at cycle 30.
REQ-039 Collision: LD_REQ and START both high for 2 cycles, then LD_REQ=0 -> 2 grants, then stream starts, no START lost.
REQ-040 Stall: STALL=1 for 3 cycles after index 5 is issued -> index 5 still delivered; 3 W_VALID=0 cycles; index 6 follows; total valid count=28.
REQ-041 Error/lockout: LD_ADDR=30 in IDLE -> LD_GNT=1, BRAM_EN=0, LD_ERR pulse. LD_REQ during STREAM -> LD_GNT=0 until IDLE.
REQ-042 Reset: RST at W_IDX=10 -> next cycle all outputs 0, no DONE; a new START streams from index 0.

Source files
------------

// File: rtl/neuron_weight_sequencer.sv
// rtl/neuron_weight_sequencer.sv - weight BRAM loader and sequential weight streamer for one neuron
module neuron_weight_sequencer #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ld_req_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_data_i,
    output logic          ld_gnt_o,
    output logic          ld_err_o,
    input  logic          start_i,
    input  logic          stall_i,
    output logic          busy_o,
    output logic          w_valid_o,
    output logic [AW-1:0] w_idx_o,
    output logic [DW-1:0] w_data_o,
    output logic          done_o,
    output logic [AW-1:0] bram_addr_o,
    output logic [DW-1:0] bram_di_o,
    output logic          bram_en_o,
    output logic          bram_we_o,
    input  logic [DW-1:0] bram_do_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // One extra bit so addresses up to 2**AW-1 compare correctly against DEPTH.
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          busy_q, w_valid_q, done_q, ld_err_q;
    logic [AW-1:0] w_idx_q;
    logic          grant, issue, addr_bad;

    // Next-state logic and combinational BRAM/handshake drive; reset forces everything idle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        grant       = 1'b0;
        issue       = 1'b0;
        bram_en_o   = 1'b0;
        bram_we_o   = 1'b0;
        bram_addr_o = '0;
        bram_di_o   = '0;
        addr_bad    = ({1'b0, ld_addr_i} >= DEPTH_X);
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (ld_req_i) begin
                        // Loads win; a coincident start is remembered for later.
                        grant       = 1'b1;
                        bram_en_o   = !addr_bad;
                        bram_we_o   = !addr_bad;
                        bram_addr_o = ld_addr_i;
                        bram_di_o   = ld_data_i;
                        if (start_i) begin
                            pend_d = 1'b1;
                        end
                    end else if (start_i || pend_q) begin
                        state_d = STREAM;
                        pend_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
                STREAM: begin
                    if (!stall_i) begin
                        issue       = 1'b1;
                        bram_en_o   = 1'b1;
                        bram_addr_o = cnt_q;
                        if (cnt_q == LAST) begin
                            state_d = DRAIN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register plus registered stream/status outputs aligned to the BRAM read latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            w_valid_q <= 1'b0;
            w_idx_q   <= '0;
            done_q    <= 1'b0;
            ld_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            busy_q    <= (state_d != IDLE);
            w_valid_q <= issue;
            if (issue) begin
                w_idx_q <= cnt_q;
            end
            done_q    <= issue && (cnt_q == LAST);
            ld_err_q  <= grant && addr_bad;
        end
    end

    assign ld_gnt_o  = grant;
    assign ld_err_o  = ld_err_q;
    assign busy_o    = busy_q;
    assign w_valid_o = w_valid_q;
    assign w_idx_o   = w_idx_q;
    assign w_data_o  = bram_do_i;
    assign done_o    = done_q;

endmodule

// File: tb/tb_neuron_weight_sequencer.sv
// tb/tb_neuron_weight_sequencer.sv - scoreboard bench for neuron_weight_sequencer
module tb_neuron_weight_sequencer;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, ld_req, start, stall;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_gnt, ld_err, busy, w_valid, done;
    logic [AW-1:0] w_idx, bram_addr;
    logic [DW-1:0] w_data, bram_di, bram_do;
    logic          bram_en, bram_we;

    int checks   = 0;
    int failures = 0;
    int vcnt     = 0;
    exp_t exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];

    logic [DW-1:0] bmem [2**AW];
    logic          rd_pend = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    neuron_weight_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst), .ld_req_i(ld_req), .ld_addr_i(ld_addr),
        .ld_data_i(ld_data), .ld_gnt_o(ld_gnt), .ld_err_o(ld_err),
        .start_i(start), .stall_i(stall), .busy_o(busy), .w_valid_o(w_valid),
        .w_idx_o(w_idx), .w_data_o(w_data), .done_o(done),
        .bram_addr_o(bram_addr), .bram_di_o(bram_di), .bram_en_o(bram_en),
        .bram_we_o(bram_we), .bram_do_i(bram_do)
    );

    always #5 clk = ~clk;

    // Weight BRAM: write on rising edge, read data appears on the following falling edge.
    initial bram_do = '0;
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                bmem[bram_addr] <= bram_di;
            end else begin
                rd_pend <= 1'b1;
                rd_addr <= bram_addr;
            end
        end
    end
    always @(negedge clk) begin
        if (rd_pend) begin
            bram_do <= bmem[rd_addr];
            rd_pend <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented word is popped from the scoreboard and compared.
    always begin
        @(negedge clk);
        #1;
        if (w_valid) begin
            vcnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got idx %0d expected no word", w_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("w_idx", 32'(w_idx), 32'(e.idx));
                chk("w_data", 32'(w_data), 32'(e.data));
                chk("done_on_last", 32'(done), 32'(e.idx == AW'(DEPTH - 1)));
            end
        end else if (done) begin
            chk("done_without_valid", 32'(done), 32'd0);
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        bit good;
        n = 0;
        good = (int'(a) < DEPTH);
        ld_req = 1'b1; ld_addr = a; ld_data = d;
        forever begin
            @(negedge clk); #1;
            if (ld_gnt) break;
            n++;
            if (n > 50) begin
                chk("grant_timeout", 32'(ld_gnt), 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        chk("wr_en", 32'(bram_en), 32'(good));
        if (good) begin
            chk("wr_we", 32'(bram_we), 32'd1);
            chk("wr_addr", 32'(bram_addr), 32'(a));
            chk("wr_di", 32'(bram_di), 32'(d));
            ref_mem[a] = d;
        end
        @(posedge clk); #1;
        ld_req = 1'b0;
        @(negedge clk); #1;
        chk("ld_err", 32'(ld_err), 32'(!good));
        @(posedge clk); #1;
    endtask

    // Entered and left at posedge+1. mode: 0 no stall, 1 three-cycle stall after index 5, 2 random.
    task automatic run_stream(input bit use_start, input int mode, input bit lock, input int abort_idx);
        int  k, issued, exp_done;
        bit  seen_done, fin;
        k = 0; issued = 0; exp_done = -1; seen_done = 0; fin = 0;
        vcnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back('{idx: AW'(i), data: ref_mem[i]});
        end
        start = use_start; stall = 1'b0;
        while (!fin) begin
            @(negedge clk); #1;
            if (k == 0) chk("busy_before", 32'(busy), 32'd0);
            if (k == 1) chk("busy_rise", 32'(busy), 32'd1);
            if (k == 2 && mode == 0) chk("first_valid", 32'(w_valid), 32'd1);
            if (k >= 1 && issued < DEPTH) begin
                chk("issue_en", 32'(bram_en), 32'(!stall));
                if (!stall) begin
                    chk("issue_addr", 32'(bram_addr), 32'(issued));
                    issued++;
                    if (issued == DEPTH) exp_done = k + 1;
                end
            end
            if (ld_req) chk("lockout_gnt", 32'(ld_gnt), 32'd0);
            if (abort_idx >= 0 && w_valid && int'(w_idx) == abort_idx) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_valid", 32'(w_valid), 32'd0);
                chk("rst_idx", 32'(w_idx), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_en", 32'(bram_en), 32'd0);
                chk("abort_no_done", 32'(seen_done), 32'd0);
                rst = 1'b0; stall = 1'b0; ld_req = 1'b0; start = 1'b0;
                exp_q.delete();
                return;
            end
            if (done) begin
                seen_done = 1;
                chk("done_cycle", 32'(k), 32'(exp_done));
            end
            if (seen_done && k == exp_done + 1) begin
                chk("busy_fall", 32'(busy), 32'd0);
                fin = 1;
            end
            if (k > 200) begin
                chk("stream_timeout", 32'(seen_done), 32'd1);
                fin = 1;
            end
            @(posedge clk); #1;
            k++;
            start = 1'b0;
            if (mode == 1)      stall = (k >= 7 && k <= 9);
            else if (mode == 2) stall = ($urandom_range(0, 3) == 0);
            else                stall = 1'b0;
            ld_req  = lock && (k >= 1) && !seen_done;
            ld_addr = AW'($urandom_range(0, DEPTH - 1));
        end
        stall = 1'b0; ld_req = 1'b0;
        chk("valid_count", 32'(vcnt), 32'(DEPTH));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; ld_req = 1'b1; ld_addr = 5'd7; ld_data = 16'hABCD;
        start = 1'b1; stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_gnt", 32'(ld_gnt), 32'd0);
        chk("reset_en", 32'(bram_en), 32'd0);
        chk("reset_we", 32'(bram_we), 32'd0);
        chk("reset_addr", 32'(bram_addr), 32'd0);
        chk("reset_di", 32'(bram_di), 32'd0);
        chk("reset_outs", {27'd0, busy, w_valid, done, ld_err, 1'b0}, 32'd0);
        chk("reset_idx", 32'(w_idx), 32'd0);
        rst = 1'b0; ld_req = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("no_pending_from_reset", 32'(busy), 32'd0);

        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'(i + 1));
        run_stream(1, 0, 0, -1);

        do_write(5'd30, 16'h1234);
        @(negedge clk); #1;
        chk("ld_err_single_pulse", 32'(ld_err), 32'd0);
        @(posedge clk); #1;
        do_write(5'd31, 16'h5678);

        ld_req = 1'b1; start = 1'b1;
        ld_addr = 5'd3; ld_data = DW'($urandom);
        @(negedge clk); #1;
        chk("collide_gnt0", 32'(ld_gnt), 32'd1);
        @(posedge clk); #1;
        ref_mem[3] = ld_data;
        ld_addr = 5'd20; ld_data = DW'($urandom);
        @(negedge clk); #1;
        chk("collide_gnt1", 32'(ld_gnt), 32'd1);
        @(posedge clk); #1;
        ref_mem[20] = ld_data;
        ld_req = 1'b0;
        run_stream(0, 0, 0, -1);

        run_stream(1, 1, 0, -1);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) do_write(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
            run_stream(1, 2, 1, -1);
        end

        run_stream(1, 0, 0, 10);
        run_stream(1, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
